// File: rtl/regfile_bypass_pkg.sv
// rtl/regfile_bypass_pkg.sv - shared types and stage-bus widths for the bypassing register file
package regfile_bypass_pkg;

  // Which stage a read byte is taken from; youngest has the highest value.
  typedef enum logic [1:0] {
    SRC_ARRAY = 2'd0,
    SRC_WB    = 2'd1,
    SRC_MEM   = 2'd2,
    SRC_EX    = 2'd3
  } fwd_src_e;

  function automatic int ex_to_id_wd(input int sb, input int aw, input int dw);
    return sb + aw + dw + 1;
  endfunction

  function automatic int mem_to_id_wd(input int sb, input int aw, input int dw);
    return sb + aw + dw;
  endfunction

  function automatic int wb_to_id_wd(input int sb, input int aw, input int dw);
    return sb + aw + dw;
  endfunction

endpackage

// File: rtl/regfile_bypass_byte_mux.sv
// rtl/regfile_bypass_byte_mux.sv - one byte lane of a read port: EX > MEM > WB > array priority select
module regfile_bypass_byte_mux
  import regfile_bypass_pkg::*;
(
  input  logic       zero,
  input  logic       ex_hit,
  input  logic       mem_hit,
  input  logic       wb_hit,
  input  logic [7:0] ex_byte,
  input  logic [7:0] mem_byte,
  input  logic [7:0] wb_byte,
  input  logic [7:0] arr_byte,
  output logic [7:0] dout
);

  fwd_src_e src;

  always_comb begin
    src = SRC_ARRAY;
    if (ex_hit)       src = SRC_EX;
    else if (mem_hit) src = SRC_MEM;
    else if (wb_hit)  src = SRC_WB;
  end

  always_comb begin
    dout = arr_byte;
    if (zero) begin
      dout = 8'h00;
    end else begin
      case (src)
        SRC_EX:  dout = ex_byte;
        SRC_MEM: dout = mem_byte;
        SRC_WB:  dout = wb_byte;
        default: dout = arr_byte;
      endcase
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - NREG x DW register file with per-byte EX/MEM/WB forwarding and load-use stall
// Optional HI/LO register pair is built when REGFILE_HILO_EN is defined.
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR-1:0]      rden,
  input  logic [NR*AW-1:0]   raddr,
  output logic [NR*DW-1:0]   rdata,
  input  logic [DW/8-1:0]    we,
  input  logic [AW-1:0]      waddr,
  input  logic [DW-1:0]      wdata,
  input  logic [DW/8-1:0]    ex_wstrb,
  input  logic [AW-1:0]      ex_waddr,
  input  logic [DW-1:0]      ex_wdata,
  input  logic               ex_is_load,
  input  logic [DW/8-1:0]    mem_wstrb,
  input  logic [AW-1:0]      mem_waddr,
  input  logic [DW-1:0]      mem_wdata,
  input  logic [DW/8-1:0]    wb_wstrb,
  input  logic [AW-1:0]      wb_waddr,
  input  logic [DW-1:0]      wb_wdata,
`ifdef REGFILE_HILO_EN
  input  logic [1:0]         hilo_we,
  input  logic [DW-1:0]      hi_wdata,
  input  logic [DW-1:0]      lo_wdata,
  input  logic [1:0]         ex_hilo_we,
  input  logic [DW-1:0]      ex_hi,
  input  logic [DW-1:0]      ex_lo,
  input  logic [1:0]         mem_hilo_we,
  input  logic [DW-1:0]      mem_hi,
  input  logic [DW-1:0]      mem_lo,
  output logic [DW-1:0]      hi_rdata,
  output logic [DW-1:0]      lo_rdata,
`endif
  output logic               stall_req
);

  localparam int SB   = DW / 8;
  localparam int NREG = 2 ** AW;

  logic [DW-1:0] regs [NREG];

  // Register 0 is never written, so the array entry stays 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (waddr != '0) begin
      for (int k = 0; k < SB; k++) begin
        if (we[k]) regs[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    stall_req = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (!rst && rden[i] && ex_is_load && (|ex_wstrb) && ex_waddr != '0 &&
          ex_waddr == raddr[i*AW +: AW])
        stall_req = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_port
    logic [AW-1:0] ra;
    logic [DW-1:0] arr_word;
    assign ra       = raddr[gi*AW +: AW];
    assign arr_word = regs[ra];

    // A pending load in EX never forwards; its bytes fall through to older stages.
    for (genvar gk = 0; gk < SB; gk++) begin : g_byte
      regfile_bypass_byte_mux u_mux (
        .zero     (ra == '0),
        .ex_hit   (ex_waddr == ra && ex_wstrb[gk] && !ex_is_load),
        .mem_hit  (mem_waddr == ra && mem_wstrb[gk]),
        .wb_hit   (wb_waddr == ra && wb_wstrb[gk]),
        .ex_byte  (ex_wdata[8*gk +: 8]),
        .mem_byte (mem_wdata[8*gk +: 8]),
        .wb_byte  (wb_wdata[8*gk +: 8]),
        .arr_byte (arr_word[8*gk +: 8]),
        .dout     (rdata[gi*DW + 8*gk +: 8])
      );
    end
  end

`ifdef REGFILE_HILO_EN
  logic [DW-1:0] hi_q;
  logic [DW-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hilo_we[1]) hi_q <= hi_wdata;
      if (hilo_we[0]) lo_q <= lo_wdata;
    end
  end

  assign hi_rdata = ex_hilo_we[1]  ? ex_hi  :
                    mem_hilo_we[1] ? mem_hi :
                    hilo_we[1]     ? hi_wdata : hi_q;
  assign lo_rdata = ex_hilo_we[0]  ? ex_lo  :
                    mem_hilo_we[0] ? mem_lo :
                    hilo_we[0]     ? lo_wdata : lo_q;
`else
`endif

endmodule

// File: tb/tb_regfile_bypass.sv
// tb/tb_regfile_bypass.sv - directed and randomized checks of regfile_bypass against a word-level model
module tb_regfile_bypass;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int SB   = DW / 8;
  localparam int NREG = 2 ** AW;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      rden;
  logic [NR*AW-1:0]   raddr;
  logic [NR*DW-1:0]   rdata;
  logic [SB-1:0]      we;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic [SB-1:0]      ex_wstrb;
  logic [AW-1:0]      ex_waddr;
  logic [DW-1:0]      ex_wdata;
  logic               ex_is_load;
  logic [SB-1:0]      mem_wstrb;
  logic [AW-1:0]      mem_waddr;
  logic [DW-1:0]      mem_wdata;
  logic [SB-1:0]      wb_wstrb;
  logic [AW-1:0]      wb_waddr;
  logic [DW-1:0]      wb_wdata;
  logic               stall_req;

  regfile_bypass #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .rden       (rden),
    .raddr      (raddr),
    .rdata      (rdata),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .ex_wstrb   (ex_wstrb),
    .ex_waddr   (ex_waddr),
    .ex_wdata   (ex_wdata),
    .ex_is_load (ex_is_load),
    .mem_wstrb  (mem_wstrb),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .wb_wstrb   (wb_wstrb),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] mdl [NREG];

  // Architectural value as seen from ID: start from the stored word and
  // overlay progressively younger in-flight writes, byte by byte.
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = mdl[a];
    for (int k = 0; k < SB; k++) if (wb_waddr == a && wb_wstrb[k]) v[8*k +: 8] = wb_wdata[8*k +: 8];
    for (int k = 0; k < SB; k++) if (mem_waddr == a && mem_wstrb[k]) v[8*k +: 8] = mem_wdata[8*k +: 8];
    if (!ex_is_load)
      for (int k = 0; k < SB; k++) if (ex_waddr == a && ex_wstrb[k]) v[8*k +: 8] = ex_wdata[8*k +: 8];
    return v;
  endfunction

  function automatic logic exp_stall();
    if (rst || !ex_is_load || ex_wstrb == 0 || ex_waddr == 0) return 1'b0;
    for (int i = 0; i < NR; i++)
      if (rden[i] && raddr[i*AW +: AW] == ex_waddr) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_model(input string tag);
    logic [DW-1:0] got, exp;
    for (int i = 0; i < NR; i++) begin
      got = rdata[i*DW +: DW];
      exp = exp_read(raddr[i*AW +: AW]);
      vectors++;
      assert (got === exp) else begin
        miscompares++;
        $error("FAIL %s rdata%0d got %h expected %h", tag, i, got, exp);
      end
    end
    vectors++;
    assert (stall_req === exp_stall()) else begin
      miscompares++;
      $error("FAIL %s stall_req got %b expected %b", tag, stall_req, exp_stall());
    end
  endtask

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < NREG; r++) mdl[r] = '0;
    end else if (waddr != 0) begin
      for (int k = 0; k < SB; k++) if (we[k]) mdl[waddr][8*k +: 8] = wdata[8*k +: 8];
    end
    #2;
  endtask

  task automatic set_wb(input logic [SB-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = s; waddr = a; wdata = d;
    wb_wstrb = s; wb_waddr = a; wb_wdata = d;
  endtask

  task automatic clear_fwd();
    set_wb('0, '0, '0);
    ex_wstrb = '0; ex_waddr = '0; ex_wdata = '0; ex_is_load = 1'b0;
    mem_wstrb = '0; mem_waddr = '0; mem_wdata = '0;
    rden = '0;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) mdl[r] = '0;
    rst = 1'b1;
    raddr = '0;
    clear_fwd();
    tick();
    tick();

    // reset held: matching EX load must not stall
    ex_is_load = 1'b1; ex_wstrb = 4'hF; ex_waddr = 5'd7;
    raddr = {5'd7, 5'd7}; rden = 2'b11;
    #1;
    check_val("stall_in_reset", {31'd0, stall_req}, 32'd0);
    check_model("reset_model");
    clear_fwd();
    rst = 1'b0;
    tick();

    for (int a = 0; a < NREG; a += 2) begin
      raddr = {5'(a + 1), 5'(a)};
      #1;
      check_val("reset_read_p0", rdata[DW-1:0], 32'd0);
      check_val("reset_read_p1", rdata[2*DW-1:DW], 32'd0);
    end

    // WB write with same-cycle bypass, then from the array
    raddr = {5'd0, 5'd5};
    set_wb(4'hF, 5'd5, 32'h12345678);
    #1;
    check_val("wb_bypass", rdata[DW-1:0], 32'h12345678);
    tick();
    clear_fwd();
    #1;
    check_val("array_read", rdata[DW-1:0], 32'h12345678);

    // MEM sb merges one byte over the stored word
    mem_wstrb = 4'b0001; mem_waddr = 5'd5; mem_wdata = 32'h000000AB;
    #1;
    check_val("mem_sb_merge", rdata[DW-1:0], 32'h123456AB);
    clear_fwd();

    // EX > MEM > WB priority
    raddr = {5'd0, 5'd3};
    ex_wstrb = 4'hF; ex_waddr = 5'd3; ex_wdata = 32'h11111111;
    mem_wstrb = 4'hF; mem_waddr = 5'd3; mem_wdata = 32'h22222222;
    set_wb(4'hF, 5'd3, 32'h33333333);
    #1;
    check_val("prio_ex", rdata[DW-1:0], 32'h11111111);
    ex_wstrb = 4'h0;
    #1;
    check_val("prio_mem", rdata[DW-1:0], 32'h22222222);
    tick();
    clear_fwd();

    // load-use stall
    ex_is_load = 1'b1; ex_wstrb = 4'hF; ex_waddr = 5'd7; ex_wdata = 32'h55555555;
    raddr = {5'd7, 5'd0}; rden = 2'b10;
    #1;
    check_val("stall_hit", {31'd0, stall_req}, 32'd1);
    check_model("stall_hit_model");
    rden = 2'b00;
    #1;
    check_val("stall_rden0", {31'd0, stall_req}, 32'd0);
    rden = 2'b10; ex_waddr = 5'd0;
    #1;
    check_val("stall_r0", {31'd0, stall_req}, 32'd0);
    ex_waddr = 5'd7;
    tick();
    ex_is_load = 1'b0; ex_wstrb = '0; ex_waddr = '0;
    mem_wstrb = 4'hF; mem_waddr = 5'd7; mem_wdata = 32'hDEADBEEF;
    #1;
    check_val("stall_clear", {31'd0, stall_req}, 32'd0);
    check_val("load_mem_fwd", rdata[2*DW-1:DW], 32'hDEADBEEF);
    clear_fwd();

    // r0 stays zero no matter who targets it
    raddr = '0;
    set_wb(4'hF, 5'd0, 32'hFFFFFFFF);
    ex_wstrb = 4'hF; ex_waddr = 5'd0; ex_wdata = 32'hFFFFFFFF;
    mem_wstrb = 4'hF; mem_waddr = 5'd0; mem_wdata = 32'hFFFFFFFF;
    #1;
    check_val("r0_fwd_p0", rdata[DW-1:0], 32'd0);
    check_val("r0_fwd_p1", rdata[2*DW-1:DW], 32'd0);
    tick();
    clear_fwd();
    #1;
    check_val("r0_array", rdata[DW-1:0], 32'd0);

    // reset wins over a simultaneous write
    set_wb(4'hF, 5'd9, 32'hAAAAAAAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_fwd();
    raddr = {5'd5, 5'd9};
    #1;
    check_val("reset_wins", rdata[DW-1:0], 32'd0);
    check_val("reset_cleared_r5", rdata[2*DW-1:DW], 32'd0);

    // randomized traffic over a small address window to provoke hits
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rden = 2'($urandom);
      set_wb(4'($urandom), 5'($urandom_range(0, 7)), $urandom);
      ex_wstrb = 4'($urandom); ex_waddr = 5'($urandom_range(0, 7));
      ex_wdata = $urandom; ex_is_load = ($urandom_range(0, 3) == 0);
      mem_wstrb = 4'($urandom); mem_waddr = 5'($urandom_range(0, 7));
      mem_wdata = $urandom;
      #1;
      check_model("random");
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
